// File: rtl/sysid_pkg.sv
// sysid_pkg: shared state encoding, slave word addresses and default build constants for the sysid boot checker
package sysid_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ_ID, S_LAT_ID, S_REQ_TS, S_LAT_TS, S_CHECK} state_t;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam logic [31:0] SYSID_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1346454016;
endpackage

// File: rtl/sysid_rd_timer.sv
// sysid_rd_timer: read-latency down-counter plus waitrequest stall counter with terminal-count flag
module sysid_rd_timer #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic lat_load,
  input  logic lat_run,
  input  logic stall_clr,
  input  logic stall_inc,
  output logic lat_last,
  output logic stall_tc
);
  logic [2:0]  lat_cnt;
  logic [15:0] stall_cnt;
  // latency counter reloads on read acceptance; stall counter restarts for every new request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      lat_cnt   <= lat_load ? 3'(READ_LATENCY) : (lat_run && lat_cnt != 3'd0) ? lat_cnt - 3'd1 : lat_cnt;
      stall_cnt <= stall_clr ? 16'd0 : stall_inc ? stall_cnt + 16'd1 : stall_cnt;
    end
  end
  assign lat_last = lat_cnt == 3'd1;
  assign stall_tc = stall_cnt == 16'(TIMEOUT_CYCLES);
endmodule

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads sysid ID/timestamp words and flags image mismatch; SYSID_CHECK_TIMESTAMP_EN adds the timestamp to id_ok
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);
  state_t state;
  logic   auto_go, in_req, accept, lat_last, stall_tc, ts_ok;
  assign in_req = state == S_REQ_ID || state == S_REQ_TS;
  assign accept = in_req && !avm_waitrequest;
`ifdef SYSID_CHECK_TIMESTAMP_EN
  assign ts_ok = captured_ts == EXPECTED_TS;
`else
  assign ts_ok = 1'b1;
`endif
  sysid_rd_timer #(.READ_LATENCY(READ_LATENCY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .lat_load  (accept),
    .lat_run   (state == S_LAT_ID || state == S_LAT_TS),
    .stall_clr (!in_req || accept),
    .stall_inc (in_req && avm_waitrequest),
    .lat_last  (lat_last),
    .stall_tc  (stall_tc)
  );
  // check sequencer: ID read, TS read, compare; a stalled read past the limit aborts with timeout
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      auto_go     <= 1'b1;
      avm_address <= SYSID_ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      case (state)
        S_IDLE: if (start || auto_go) begin
          auto_go     <= 1'b0;
          done        <= 1'b0;
          id_ok       <= 1'b0;
          timeout     <= 1'b0;
          busy        <= 1'b1;
          avm_read    <= 1'b1;
          avm_address <= SYSID_ADDR_ID;
          state       <= S_REQ_ID;
        end
        S_REQ_ID: if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            captured_id <= avm_readdata;
            avm_address <= SYSID_ADDR_TS;
            state       <= S_REQ_TS;
          end else begin
            avm_read <= 1'b0;
            state    <= S_LAT_ID;
          end
        end else if (stall_tc) begin
          avm_read <= 1'b0;
          timeout  <= 1'b1;
          id_ok    <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        S_LAT_ID: if (lat_last) begin
          captured_id <= avm_readdata;
          avm_read    <= 1'b1;
          avm_address <= SYSID_ADDR_TS;
          state       <= S_REQ_TS;
        end
        S_REQ_TS: if (!avm_waitrequest) begin
          avm_read <= 1'b0;
          if (READ_LATENCY == 0) captured_ts <= avm_readdata;
          state <= READ_LATENCY == 0 ? S_CHECK : S_LAT_TS;
        end else if (stall_tc) begin
          avm_read <= 1'b0;
          timeout  <= 1'b1;
          id_ok    <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        S_LAT_TS: if (lat_last) begin
          captured_ts <= avm_readdata;
          state       <= S_CHECK;
        end
        S_CHECK: begin
          id_ok <= captured_id == EXPECTED_ID && ts_ok;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: random sysid contents against a behavioural model, zero- and two-cycle-latency slaves
module tb_sysid_boot_checker;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1346454016;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, wait_req = 1'b0;
  logic [31:0] mem0 = '0, mem1 = '0, last_id = '0, last_ts = '0;
  logic addr_a, read_a, busy_a, done_a, ok_a, to_a;
  logic addr_b, read_b, busy_b, done_b, ok_b, to_b;
  logic [31:0] rd_a, cid_a, cts_a, rd_b, cid_b, cts_b;
  logic [1:0] pv = '0, pa = '0;
  int total = 0, bad = 0;
  always #5 clock = ~clock;
  assign rd_a = addr_a ? mem1 : mem0;
  // two-cycle slave: data is only meaningful two cycles after acceptance, junk otherwise
  always @(posedge clock) begin
    pv <= {pv[0], read_b && !wait_req};
    pa <= {pa[0], addr_b};
  end
  assign rd_b = pv[1] ? (pa[1] ? mem1 : mem0) : 32'hA5A5_5A5A;
  sysid_boot_checker u_a (
    .clock(clock), .reset_n(reset_n), .start(start), .avm_address(addr_a), .avm_read(read_a),
    .avm_waitrequest(wait_req), .avm_readdata(rd_a), .busy(busy_a), .done(done_a), .id_ok(ok_a),
    .timeout(to_a), .captured_id(cid_a), .captured_ts(cts_a));
  sysid_boot_checker #(.READ_LATENCY(2)) u_b (
    .clock(clock), .reset_n(reset_n), .start(start), .avm_address(addr_b), .avm_read(read_b),
    .avm_waitrequest(wait_req), .avm_readdata(rd_b), .busy(busy_b), .done(done_b), .id_ok(ok_b),
    .timeout(to_b), .captured_id(cid_b), .captured_ts(cts_b));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  function automatic logic exp_ok(input logic [31:0] id, input logic [31:0] ts);
`ifdef SYSID_CHECK_TIMESTAMP_EN
    return id == EXP_ID && ts == EXP_TS;
`else
    return id == EXP_ID && (ts == ts);
`endif
  endfunction
  // one check run with no stalls: done lands 4 + 2*latency cycles after the trigger cycle
  task automatic run(input string tag, input bit use_start);
    int na = 0, nb = 0;
    if (use_start) start = 1'b1;
    for (int n = 1; n <= 40 && (na == 0 || nb == 0); n++) begin
      step();
      start = 1'b0;
      if (n == 1) check({tag, "_busy1"}, {30'd0, busy_a, busy_b}, 32'd3);
      if (done_a && na == 0) na = n;
      if (done_b && nb == 0) nb = n;
    end
    check({tag, "_lat_a"}, na, 4);
    check({tag, "_lat_b"}, nb, 8);
    check({tag, "_ok_a"}, ok_a, exp_ok(mem0, mem1));
    check({tag, "_ok_b"}, ok_b, exp_ok(mem0, mem1));
    check({tag, "_id_a"}, cid_a, mem0);
    check({tag, "_id_b"}, cid_b, mem0);
    check({tag, "_ts_a"}, cts_a, mem1);
    check({tag, "_ts_b"}, cts_b, mem1);
    check({tag, "_idle"}, {28'd0, busy_a, busy_b, to_a, to_b}, 32'd0);
    last_id = mem0;
    last_ts = mem1;
  endtask
  initial begin
    int ta, tb, ra, rb;
    logic pa_busy, pb_busy;
    mem0 = EXP_ID;
    mem1 = EXP_TS;
    step();
    step();
    check("reset_out", {26'd0, read_a, busy_a, done_a, ok_a, to_a, read_b}, 32'd0);
    check("reset_cap", cid_a | cts_a | cid_b | cts_b, 32'd0);
    reset_n = 1'b1;
    run("boot", 1'b0);
    mem0 = 32'h0000_0001;
    run("badid", 1'b1);
    mem0 = EXP_ID;
    mem1 = 32'd0;
    run("ts0", 1'b1);
    for (int i = 0; i < 10; i++) begin
      mem0 = $urandom_range(0, 1) ? EXP_ID : $urandom;
      case ($urandom_range(0, 2))
        0: mem1 = EXP_TS;
        1: mem1 = 32'd0;
        default: mem1 = $urandom;
      endcase
      for (int g = $urandom_range(0, 4); g > 0; g--) step();
      run($sformatf("rnd%0d", i), 1'b1);
    end
    // stalled slave: abort after the stall counter reaches its limit
    mem0 = 32'h0000_1234;
    mem1 = 32'h0000_5678;
    wait_req = 1'b1;
    start = 1'b1;
    ta = 0;
    tb = 0;
    for (int n = 1; n <= 300; n++) begin
      step();
      start = 1'b0;
      if (n == 100) check("stall_hold", {29'd0, read_a, addr_a, busy_a}, 32'd5);
      if (to_a && ta == 0) ta = n;
      if (to_b && tb == 0) tb = n;
    end
    wait_req = 1'b0;
    check("to_lat_a", ta, 257);
    check("to_lat_b", tb, 257);
    check("to_flags_a", {28'd0, done_a, ok_a, read_a, busy_a}, 32'd8);
    check("to_flags_b", {28'd0, done_b, ok_b, read_b, busy_b}, 32'd8);
    check("to_keep_id", cid_a, last_id);
    check("to_keep_ts", cts_b, last_ts);
    mem0 = EXP_ID;
    mem1 = EXP_TS;
    run("recover", 1'b1);
    // reset while the TS read is outstanding
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("mid_state", {31'd0, addr_a}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst", {26'd0, read_a, busy_a, done_a, ok_a, busy_b, read_b}, 32'd0);
    check("mid_rst_cap", cid_a | cid_b, 32'd0);
    step();
    reset_n = 1'b1;
    run("rerun", 1'b0);
    // start pulses while busy must not spawn extra runs
    start = 1'b1;
    step();
    pa_busy = busy_a;
    pb_busy = busy_b;
    ra = 0;
    rb = 0;
    for (int n = 1; n < 30; n++) begin
      start = n <= 2;
      step();
      if (busy_a && !pa_busy) ra++;
      if (busy_b && !pb_busy) rb++;
      pa_busy = busy_a;
      pb_busy = busy_b;
    end
    start = 1'b0;
    check("busy_rerun_a", ra, 0);
    check("busy_rerun_b", rb, 0);
    check("busy_done", {30'd0, done_a, done_b}, 32'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
